// File: rtl/dmamaster.sv
// dmamaster: ARM-programmed Unibus NPR master. Each start command runs one bus
// cycle (DATI, DATIP, DATO or DATOB). A small register file handles setup and status.
//
// state  | meaning
// IDLE   | no transfer in progress; all bus outputs released
// REQ    | NPR asserted, waiting for the grant
// GRANT  | grant accepted (SACK held), waiting for the bus and the grant to drop
// DESKEW | bus owned, address/data settling before MSYN
// MSYN   | MSYN asserted, waiting for SSYN or the timeout
// DONE   | MSYN dropped, waiting for the slave to release SSYN
`timescale 1ns/1ps
module dmamaster (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        armwrite,
  input  logic [1:0]  armraddr,
  input  logic [1:0]  armwaddr,
  input  logic [31:0] armwdata,
  output logic [31:0] armrdata,
  input  logic [15:0] d_in_h,
  input  logic        npg_in_h,
  input  logic        ssyn_in_h,
  input  logic        bbsy_in_h,
  input  logic        sack_in_h,
  input  logic        init_in_h,
  output logic [17:0] a_out_h,
  output logic [1:0]  c_out_h,
  output logic [15:0] d_out_h,
  output logic        npr_out_h,
  output logic        sack_out_h,
  output logic        bbsy_out_h,
  output logic        msyn_out_h
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_GRANT  = 3'd2,
    ST_DESKEW = 3'd3,
    ST_MSYN   = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  localparam logic [31:0] ID_WORD      = 32'h444D1001;
  // Counter compares one below the dwell length because the exit edge is itself a counted cycle.
  localparam logic [9:0]  DESKEW_LAST  = 10'd14;
  localparam logic [9:0]  TIMEOUT_LAST = 10'd1022;

  state_t      state;
  logic        busy;
  logic        timeout;
  logic [17:0] addr;
  logic [1:0]  c;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic [9:0]  cnt;

  logic        wr_ctl;
  logic        wr_data;
  logic        start_req;
  logic        abort_req;
  logic [10:0] unused_bits;

  assign wr_ctl    = armwrite && (armwaddr == 2'd1);
  assign wr_data   = armwrite && (armwaddr == 2'd2);
  assign start_req = wr_ctl && armwdata[31] && !busy;
  assign abort_req = wr_ctl && armwdata[30];
  // sack_in_h from other masters has no effect here; unmapped write-data bits are don't-care.
  assign unused_bits = {sack_in_h, armwdata[27:18]};

  // Register read mux, combinational from the read index.
  always_comb begin
    armrdata = 32'h0;
    case (armraddr)
      2'd0:    armrdata = ID_WORD;
      2'd1:    armrdata = {busy, timeout, c, 10'b0, addr};
      2'd2:    armrdata = {rdata, wdata};
      2'd3:    armrdata = {29'b0, state};
      default: armrdata = 32'h0;
    endcase
  end

  // Transfer sequencer with registered bus outputs; bus INIT aborts without touching config.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      timeout    <= 1'b0;
      addr       <= 18'h0;
      c          <= 2'b00;
      wdata      <= 16'h0;
      rdata      <= 16'h0;
      cnt        <= 10'h0;
      a_out_h    <= 18'h0;
      c_out_h    <= 2'b00;
      d_out_h    <= 16'h0;
      npr_out_h  <= 1'b0;
      sack_out_h <= 1'b0;
      bbsy_out_h <= 1'b0;
      msyn_out_h <= 1'b0;
    end else if (init_in_h) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      a_out_h    <= 18'h0;
      c_out_h    <= 2'b00;
      d_out_h    <= 16'h0;
      npr_out_h  <= 1'b0;
      sack_out_h <= 1'b0;
      bbsy_out_h <= 1'b0;
      msyn_out_h <= 1'b0;
    end else begin
      if (wr_data) begin
        wdata <= armwdata[15:0];
      end
      case (state)
        ST_IDLE: begin
          if (start_req) begin
            c         <= armwdata[29:28];
            addr      <= armwdata[17:0];
            timeout   <= 1'b0;
            busy      <= 1'b1;
            npr_out_h <= 1'b1;
            state     <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (abort_req) begin
            busy      <= 1'b0;
            npr_out_h <= 1'b0;
            state     <= ST_IDLE;
          end else if (npg_in_h) begin
            npr_out_h  <= 1'b0;
            sack_out_h <= 1'b1;
            state      <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (abort_req) begin
            busy       <= 1'b0;
            sack_out_h <= 1'b0;
            state      <= ST_IDLE;
          end else if (!bbsy_in_h && !ssyn_in_h && !npg_in_h) begin
            sack_out_h <= 1'b0;
            bbsy_out_h <= 1'b1;
            a_out_h    <= addr;
            c_out_h    <= c;
            d_out_h    <= c[1] ? wdata : 16'h0;
            cnt        <= 10'h0;
            state      <= ST_DESKEW;
          end
        end
        ST_DESKEW: begin
          if (cnt == DESKEW_LAST) begin
            msyn_out_h <= 1'b1;
            cnt        <= 10'h0;
            state      <= ST_MSYN;
          end else begin
            cnt <= cnt + 10'd1;
          end
        end
        ST_MSYN: begin
          if (ssyn_in_h) begin
            if (!c[1]) begin
              rdata <= d_in_h;
            end
            msyn_out_h <= 1'b0;
            state      <= ST_DONE;
          end else begin
            cnt <= cnt + 10'd1;
            if (cnt == TIMEOUT_LAST) begin
              timeout    <= 1'b1;
              msyn_out_h <= 1'b0;
              state      <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (!ssyn_in_h) begin
            bbsy_out_h <= 1'b0;
            a_out_h    <= 18'h0;
            c_out_h    <= 2'b00;
            d_out_h    <= 16'h0;
            busy       <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmamaster.sv
`timescale 1ns/1ps
module tb_dmamaster;
  logic        CLOCK = 1'b0;
  logic        RESET;
  logic        armwrite;
  logic [1:0]  armraddr, armwaddr;
  logic [31:0] armwdata, armrdata;
  logic [15:0] d_in_h;
  logic        npg_in_h, ssyn_in_h, bbsy_in_h, sack_in_h, init_in_h;
  logic [17:0] a_out_h;
  logic [1:0]  c_out_h;
  logic [15:0] d_out_h;
  logic        npr_out_h, sack_out_h, bbsy_out_h, msyn_out_h;

  int checks = 0;
  int errors = 0;

  // reference model of the programmer-visible state
  logic [17:0] m_addr;
  logic [1:0]  m_c;
  logic [15:0] m_wdata, m_rdata;
  logic        m_timeout;

  // observations from the last transfer
  int          o_deskew, o_msyn_len, o_grab, o_rel;
  logic [17:0] o_a;
  logic [1:0]  o_c;
  logic [15:0] o_d;
  logic [39:0] o_idle;
  bit          o_npr_ok, o_sack_ok, o_bbsy_ok, o_hold_ok, o_bound_ok;

  dmamaster dut (
    .CLOCK(CLOCK), .RESET(RESET), .armwrite(armwrite), .armraddr(armraddr),
    .armwaddr(armwaddr), .armwdata(armwdata), .armrdata(armrdata), .d_in_h(d_in_h),
    .npg_in_h(npg_in_h), .ssyn_in_h(ssyn_in_h), .bbsy_in_h(bbsy_in_h),
    .sack_in_h(sack_in_h), .init_in_h(init_in_h), .a_out_h(a_out_h), .c_out_h(c_out_h),
    .d_out_h(d_out_h), .npr_out_h(npr_out_h), .sack_out_h(sack_out_h),
    .bbsy_out_h(bbsy_out_h), .msyn_out_h(msyn_out_h)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic tick();
    @(negedge CLOCK);
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
    armwaddr = a; armwdata = d; armwrite = 1'b1;
    tick();
    armwrite = 1'b0;
  endtask

  task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
    armraddr = a;
    #1;
    d = armrdata;
  endtask

  function automatic logic [31:0] exp_reg1();
    return {1'b0, m_timeout, m_c, 10'b0, m_addr};
  endfunction

  // Full bus transfer with a simple slave; records what the master did.
  task automatic do_transfer(input logic [1:0] c, input logic [17:0] addr, input logic [15:0] wd,
                             input logic [15:0] din, input int npg_dly, input int busy_cyc,
                             input int ssyn_dly, input bit intrude);
    int k;
    m_addr = addr; m_c = c; m_wdata = wd;
    m_timeout = (ssyn_dly < 0);
    if (ssyn_dly >= 0 && !c[1]) m_rdata = din;
    o_npr_ok = 1; o_sack_ok = 1; o_bbsy_ok = 1; o_hold_ok = 1; o_bound_ok = 1;
    o_deskew = -1; o_msyn_len = -1; o_grab = -1; o_rel = -1;
    o_a = '1; o_c = '1; o_d = '1; o_idle = '1;
    reg_write(2'd2, {16'h0, wd});
    reg_write(2'd1, {2'b10, c, 10'b0, addr});
    if (intrude) begin
      if (npr_out_h !== 1'b1) o_npr_ok = 0;
      reg_write(2'd1, {2'b10, ~c, 10'b0, ~addr});
    end
    for (int i = 0; i < npg_dly; i++) begin
      if (npr_out_h !== 1'b1) o_npr_ok = 0;
      tick();
    end
    if (npr_out_h !== 1'b1) o_npr_ok = 0;
    npg_in_h = 1'b1; bbsy_in_h = (busy_cyc > 0);
    tick();
    if (sack_out_h !== 1'b1 || npr_out_h !== 1'b0) o_sack_ok = 0;
    npg_in_h = 1'b0;
    for (int i = 0; i < busy_cyc; i++) begin
      tick();
      if (sack_out_h !== 1'b1) o_sack_ok = 0;
      if (bbsy_out_h !== 1'b0) o_bbsy_ok = 0;
    end
    bbsy_in_h = 1'b0;
    k = 0;
    while (bbsy_out_h !== 1'b1 && k < 10) begin tick(); k++; end
    o_grab = k;
    if (sack_out_h !== 1'b0) o_sack_ok = 0;
    if (bbsy_out_h !== 1'b1) o_bound_ok = 0;
    else begin
      k = 0;
      while (msyn_out_h !== 1'b1 && k < 40) begin tick(); k++; end
      o_deskew = k;
      o_a = a_out_h; o_c = c_out_h; o_d = d_out_h;
      if (msyn_out_h !== 1'b1) o_bound_ok = 0;
      else begin
        k = 0;
        while (msyn_out_h === 1'b1 && k < 1200) begin
          if (k == ssyn_dly) begin d_in_h = din; ssyn_in_h = 1'b1; end
          tick(); k++;
        end
        o_msyn_len = k;
        if (ssyn_in_h) begin
          repeat (2) begin
            if (bbsy_out_h !== 1'b1 || msyn_out_h !== 1'b0) o_hold_ok = 0;
            tick();
          end
          ssyn_in_h = 1'b0; d_in_h = 16'($urandom);
        end
        k = 0;
        while (bbsy_out_h === 1'b1 && k < 10) begin tick(); k++; end
        o_rel = k;
        if (bbsy_out_h !== 1'b0) o_bound_ok = 0;
        o_idle = {a_out_h, c_out_h, d_out_h, npr_out_h, sack_out_h, bbsy_out_h, msyn_out_h};
      end
    end
  endtask

  // Starts a DATI and walks it to: 1 REQ, 2 GRANT (grant held), 3 DESKEW, 4 MSYN.
  task automatic drive_until(input int phase, output bit ok);
    int k;
    ok = 1'b1;
    m_addr = 18'($urandom); m_c = 2'b00; m_timeout = 1'b0;
    reg_write(2'd1, {2'b10, m_c, 10'b0, m_addr});
    if (phase >= 2) begin npg_in_h = 1'b1; tick(); end
    if (phase >= 3) begin npg_in_h = 1'b0; tick(); end
    if (phase >= 4) begin
      k = 0;
      while (msyn_out_h !== 1'b1 && k < 40) begin tick(); k++; end
      if (msyn_out_h !== 1'b1) ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    RESET = 1'b1; init_in_h = 1'b0; npg_in_h = 0; ssyn_in_h = 0; bbsy_in_h = 0; sack_in_h = 0;
    d_in_h = 16'h0; armraddr = 2'd0;
    armwaddr = 2'd1; armwdata = 32'h8000_1234; armwrite = 1'b1;
    repeat (2) tick();
    RESET = 1'b0; armwrite = 1'b0;
    m_addr = 0; m_c = 0; m_wdata = 0; m_rdata = 0; m_timeout = 0;
    checks++; if ({a_out_h, c_out_h, d_out_h, npr_out_h, sack_out_h, bbsy_out_h, msyn_out_h} !== 40'h0) begin
      errors++; $display("FAIL reset_outputs got %h want 0", {a_out_h, c_out_h, d_out_h}); end
    reg_read(2'd0, rd);
    checks++; if (rd !== 32'h444D1001) begin errors++; $display("FAIL reg0_id got %h want 444d1001", rd); end
    reg_read(2'd1, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_reg1 got %h want 0", rd); end
    reg_read(2'd3, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_reg3 got %h want 0", rd); end
  endtask

  task automatic test_regs();
    logic [31:0] rd;
    logic [15:0] wd;
    wd = 16'($urandom);
    reg_write(2'd2, {16'($urandom), wd});
    m_wdata = wd;
    reg_read(2'd2, rd);
    checks++; if (rd !== {m_rdata, m_wdata}) begin errors++; $display("FAIL reg2_rw got %h want %h", rd, {m_rdata, m_wdata}); end
  endtask

  task automatic test_dati();
    logic [31:0] rd;
    do_transfer(2'b00, 18'o777570, 16'h0F0F, 16'h1234, 3, 0, 5, 1'b0);
    checks++; if (o_deskew !== 15) begin errors++; $display("FAIL dati_deskew got %0d want 15", o_deskew); end
    checks++; if (o_msyn_len !== 6) begin errors++; $display("FAIL dati_msyn_len got %0d want 6", o_msyn_len); end
    checks++; if (o_a !== 18'o777570 || o_c !== 2'b00 || o_d !== 16'h0) begin
      errors++; $display("FAIL dati_bus got %o/%b/%h want 777570/00/0", o_a, o_c, o_d); end
    reg_read(2'd2, rd);
    checks++; if (rd[31:16] !== 16'h1234) begin errors++; $display("FAIL dati_rdata got %h want 1234", rd[31:16]); end
    reg_read(2'd1, rd);
    checks++; if (rd !== exp_reg1()) begin errors++; $display("FAIL dati_reg1 got %h want %h", rd, exp_reg1()); end
    checks++; if (o_npr_ok !== 1'b1 || o_sack_ok !== 1'b1 || o_hold_ok !== 1'b1 || o_bound_ok !== 1'b1) begin
      errors++; $display("FAIL dati_handshake got %b%b%b%b want 1111", o_npr_ok, o_sack_ok, o_hold_ok, o_bound_ok); end
  endtask

  task automatic test_dato();
    logic [31:0] rd;
    logic [15:0] old_rd;
    old_rd = m_rdata;
    do_transfer(2'b10, 18'o001000, 16'hABCD, 16'h5555, 1, 0, 3, 1'b0);
    checks++; if (o_d !== 16'hABCD || o_c !== 2'b10 || o_a !== 18'o001000) begin
      errors++; $display("FAIL dato_bus got %h/%b/%o want abcd/10/001000", o_d, o_c, o_a); end
    reg_read(2'd2, rd);
    checks++; if (rd !== {old_rd, 16'hABCD}) begin errors++; $display("FAIL dato_reg2 got %h want %h", rd, {old_rd, 16'hABCD}); end
    checks++; if (o_idle !== 40'h0 || o_rel !== 1) begin
      errors++; $display("FAIL dato_release got %h after %0d want 0 after 1", o_idle, o_rel); end
  endtask

  task automatic test_bus_busy();
    do_transfer(2'b01, 18'($urandom), 16'($urandom), 16'($urandom), 2, 20, 4, 1'b0);
    checks++; if (o_sack_ok !== 1'b1) begin errors++; $display("FAIL busy_sack got %b want 1", o_sack_ok); end
    checks++; if (o_bbsy_ok !== 1'b1 || o_grab !== 1) begin
      errors++; $display("FAIL busy_bbsy got %b/%0d want 1/1", o_bbsy_ok, o_grab); end
    checks++; if (o_deskew !== 15) begin errors++; $display("FAIL busy_deskew got %0d want 15", o_deskew); end
  endtask

  task automatic test_start_while_busy();
    logic [31:0] rd;
    do_transfer(2'b11, 18'h2A5A5, 16'h1357, 16'h2468, 2, 0, 2, 1'b1);
    checks++; if (o_a !== 18'h2A5A5 || o_c !== 2'b11 || o_d !== 16'h1357) begin
      errors++; $display("FAIL busy_start_bus got %h/%b/%h want 2a5a5/11/1357", o_a, o_c, o_d); end
    reg_read(2'd1, rd);
    checks++; if (rd !== exp_reg1()) begin errors++; $display("FAIL busy_start_reg1 got %h want %h", rd, exp_reg1()); end
  endtask

  task automatic test_timeout();
    logic [31:0] rd;
    do_transfer(2'b00, 18'($urandom), 16'($urandom), 16'hDEAD, 0, 0, -1, 1'b0);
    checks++; if (o_msyn_len !== 1023) begin errors++; $display("FAIL timeout_len got %0d want 1023", o_msyn_len); end
    reg_read(2'd1, rd);
    checks++; if (rd !== exp_reg1() || rd[30] !== 1'b1) begin errors++; $display("FAIL timeout_reg1 got %h want %h", rd, exp_reg1()); end
    reg_read(2'd2, rd);
    checks++; if (rd !== {m_rdata, m_wdata}) begin errors++; $display("FAIL timeout_reg2 got %h want %h", rd, {m_rdata, m_wdata}); end
    checks++; if (o_idle !== 40'h0 || o_bound_ok !== 1'b1) begin
      errors++; $display("FAIL timeout_release got %h/%b want 0/1", o_idle, o_bound_ok); end
  endtask

  task automatic test_init();
    logic [31:0] rd;
    bit ok;
    init_in_h = 1'b1;
    reg_write(2'd1, 32'h8000_0777);
    init_in_h = 1'b0;
    reg_read(2'd1, rd);
    checks++; if (rd !== exp_reg1()) begin errors++; $display("FAIL init_idle_reg1 got %h want %h", rd, exp_reg1()); end
    drive_until(4, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL init_reach_msyn got %b want 1", ok); end
    init_in_h = 1'b1;
    reg_write(2'd2, 32'h0000_5A5A);
    init_in_h = 1'b0;
    checks++; if ({a_out_h, c_out_h, d_out_h, npr_out_h, sack_out_h, bbsy_out_h, msyn_out_h} !== 40'h0) begin
      errors++; $display("FAIL init_outputs got %b%b%b%b want 0000", npr_out_h, sack_out_h, bbsy_out_h, msyn_out_h); end
    reg_read(2'd3, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL init_state got %h want 0", rd); end
    reg_read(2'd2, rd);
    checks++; if (rd !== {m_rdata, m_wdata}) begin errors++; $display("FAIL init_reg2 got %h want %h", rd, {m_rdata, m_wdata}); end
  endtask

  task automatic test_abort();
    logic [31:0] rd;
    bit ok;
    drive_until(1, ok);
    checks++; if (npr_out_h !== 1'b1) begin errors++; $display("FAIL abort_req_npr got %b want 1", npr_out_h); end
    reg_write(2'd1, 32'h4000_0000);
    checks++; if (npr_out_h !== 1'b0) begin errors++; $display("FAIL abort_req_drop got %b want 0", npr_out_h); end
    reg_read(2'd1, rd);
    checks++; if (rd !== exp_reg1()) begin errors++; $display("FAIL abort_req_reg1 got %h want %h", rd, exp_reg1()); end
    drive_until(2, ok);
    checks++; if (sack_out_h !== 1'b1) begin errors++; $display("FAIL abort_grant_sack got %b want 1", sack_out_h); end
    reg_write(2'd1, 32'h4000_0000);
    npg_in_h = 1'b0;
    reg_read(2'd3, rd);
    checks++; if (sack_out_h !== 1'b0 || rd !== 32'h0) begin
      errors++; $display("FAIL abort_grant got sack %b state %h want 0 0", sack_out_h, rd); end
    drive_until(3, ok);
    reg_write(2'd1, 32'h4000_0000);
    reg_read(2'd3, rd);
    checks++; if (rd !== 32'h3 || bbsy_out_h !== 1'b1) begin
      errors++; $display("FAIL abort_deskew_ignored got state %h bbsy %b want 3 1", rd, bbsy_out_h); end
    init_in_h = 1'b1; tick(); init_in_h = 1'b0;
    checks++; if ({bbsy_out_h, a_out_h, c_out_h, d_out_h} !== 37'h0) begin
      errors++; $display("FAIL init_deskew got %b/%h want 0/0", bbsy_out_h, a_out_h); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    bit ok;
    drive_until(4, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rstmid_reach got %b want 1", ok); end
    RESET = 1'b1; tick();
    checks++; if ({a_out_h, c_out_h, d_out_h, npr_out_h, sack_out_h, bbsy_out_h, msyn_out_h} !== 40'h0) begin
      errors++; $display("FAIL rstmid_outputs got %b%b want 00", bbsy_out_h, msyn_out_h); end
    reg_read(2'd1, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rstmid_reg1 got %h want 0", rd); end
    RESET = 1'b0;
    m_addr = 0; m_c = 0; m_wdata = 0; m_rdata = 0; m_timeout = 0;
    reg_read(2'd2, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rstmid_reg2 got %h want 0", rd); end
  endtask

  task automatic test_random();
    logic [31:0] rd;
    logic [1:0]  c;
    logic [17:0] addr;
    logic [15:0] wd, din, ed;
    int          sd;
    for (int i = 0; i < 8; i++) begin
      c = 2'($urandom_range(0, 3)); addr = 18'($urandom); wd = 16'($urandom); din = 16'($urandom);
      sd = int'($urandom_range(0, 8));
      ed = c[1] ? wd : 16'h0;
      do_transfer(c, addr, wd, din, int'($urandom_range(0, 5)), int'($urandom_range(0, 3)), sd, 1'b0);
      checks++; if (o_deskew !== 15 || o_msyn_len !== sd + 1) begin
        errors++; $display("FAIL rand%0d timing got %0d/%0d want 15/%0d", i, o_deskew, o_msyn_len, sd + 1); end
      checks++; if (o_a !== addr || o_c !== c || o_d !== ed) begin
        errors++; $display("FAIL rand%0d bus got %h/%b/%h want %h/%b/%h", i, o_a, o_c, o_d, addr, c, ed); end
      reg_read(2'd1, rd);
      checks++; if (rd !== exp_reg1()) begin errors++; $display("FAIL rand%0d reg1 got %h want %h", i, rd, exp_reg1()); end
      reg_read(2'd2, rd);
      checks++; if (rd !== {m_rdata, m_wdata}) begin errors++; $display("FAIL rand%0d reg2 got %h want %h", i, rd, {m_rdata, m_wdata}); end
      checks++; if (o_idle !== 40'h0 || o_npr_ok !== 1'b1 || o_sack_ok !== 1'b1 || o_hold_ok !== 1'b1) begin
        errors++; $display("FAIL rand%0d handshake got %h %b%b%b want 0 111", i, o_idle, o_npr_ok, o_sack_ok, o_hold_ok); end
    end
  endtask

  initial begin
    test_reset();
    test_regs();
    test_dati();
    test_dato();
    test_bus_busy();
    test_start_while_busy();
    test_timeout();
    test_init();
    test_abort();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
